// File: rtl/gemm_mac_sequencer.sv
// Tiled GEMM sequencer around an external N-lane MAC: walks i/j/k, issues operand
// reads, accumulates chunk dot products and streams finished C elements out of a FIFO.
module gemm_mac_sequencer #(
    parameter int WIDTH     = 16,
    parameter int N         = 8,
    parameter int ACC_W     = 40,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           cfg_m,
    input  logic [7:0]           cfg_p,
    input  logic [7:0]           cfg_kc,
    output logic                 busy,
    output logic                 done,
    output logic                 a_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    b_rd_addr,
    input  logic [2*WIDTH-1:0]   mac_result,
    output logic                 c_valid,
    input  logic                 c_ready,
    output logic [ACC_W-1:0]     c_data,
    output logic [7:0]           c_row,
    output logic [7:0]           c_col
);
    localparam int TAG_LEN = RD_LAT + 1;
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W   = $clog2(OUT_DEPTH + 1);

    if (N < 1 || ACC_W < 2*WIDTH) begin : g_param_check
        $error("gemm_mac_sequencer: N must be >= 1 and ACC_W >= 2*WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [7:0] i;
        logic [7:0] j;
    } tag_t;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [7:0]       row;
        logic [7:0]       col;
    } elem_t;

    state_t             state_reg, state_next;
    logic [7:0]         m_reg, p_reg, kc_reg;
    logic [7:0]         i_reg, j_reg, k_reg;
    logic [ADDR_W-1:0]  a_addr_reg, b_addr_reg, a_row_base_reg;
    logic [CNT_W-1:0]   credit_reg;
    logic [ACC_W-1:0]   acc_reg, acc_next, mac_ext;
    logic [TAG_LEN-1:0] tag_valid;
    tag_t               issue_tag, tail;

    elem_t              fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    elem_t              head, push_elem;

    logic cfg_ok, last_k, last_j, last_i, stall, issue, take, push, pop;

    assign cfg_ok = (cfg_m != 8'd0) && (cfg_p != 8'd0) && (cfg_kc != 8'd0);
    assign last_k = (k_reg == kc_reg - 8'd1);
    assign last_j = (j_reg == p_reg - 8'd1);
    assign last_i = (i_reg == m_reg - 8'd1);
    // Only the chunk that completes an element consumes a FIFO slot, so only it waits for credit.
    assign stall  = last_k && (credit_reg == '0);
    assign issue  = (state_reg == S_RUN) && !stall;
    assign take   = issue && last_k;
    assign pop    = c_valid && c_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = cfg_ok ? S_RUN : S_DONE;
            S_RUN:   if (issue && last_k && last_j && last_i) state_next = S_DRAIN;
            S_DRAIN: if (tag_valid == '0 && count_reg == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Addresses advance incrementally; a_row_base_reg rewinds A to the row start between columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg          <= '0;
            p_reg          <= '0;
            kc_reg         <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            a_addr_reg     <= '0;
            b_addr_reg     <= '0;
            a_row_base_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            m_reg          <= cfg_m;
            p_reg          <= cfg_p;
            kc_reg         <= cfg_kc;
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            a_addr_reg     <= '0;
            b_addr_reg     <= '0;
            a_row_base_reg <= '0;
        end else if (issue) begin
            if (!last_k) begin
                k_reg      <= k_reg + 8'd1;
                a_addr_reg <= a_addr_reg + 1'b1;
                b_addr_reg <= b_addr_reg + 1'b1;
            end else begin
                k_reg <= '0;
                if (!last_j) begin
                    j_reg      <= j_reg + 8'd1;
                    b_addr_reg <= b_addr_reg + 1'b1;
                    a_addr_reg <= a_row_base_reg;
                end else begin
                    j_reg          <= '0;
                    i_reg          <= i_reg + 8'd1;
                    b_addr_reg     <= '0;
                    a_addr_reg     <= a_addr_reg + 1'b1;
                    a_row_base_reg <= a_addr_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_reg <= CNT_W'(OUT_DEPTH);
        end else if (take && !pop) begin
            credit_reg <= credit_reg - 1'b1;
        end else if (pop && !take) begin
            credit_reg <= credit_reg + 1'b1;
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = issue;
        issue_tag.first = (k_reg == 8'd0);
        issue_tag.last  = last_k;
        issue_tag.i     = i_reg;
        issue_tag.j     = j_reg;
    end

    genvar gi;
    for (gi = 0; gi < TAG_LEN; gi++) begin : g_tag
        tag_t stage_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) stage_reg <= '0;
                else     stage_reg <= issue_tag;
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) stage_reg <= '0;
                else     stage_reg <= g_tag[gi-1].stage_reg;
            end
        end
        assign tag_valid[gi] = stage_reg.valid;
    end

    assign tail    = g_tag[TAG_LEN-1].stage_reg;
    assign mac_ext = ACC_W'(signed'(mac_result));
    assign push    = tail.valid && tail.last;

    always_comb begin
        acc_next = tail.first ? mac_ext : acc_reg + mac_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (tail.valid) begin
            acc_reg <= acc_next;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push_elem      = '0;
        push_elem.data = acc_next;
        push_elem.row  = tail.i;
        push_elem.col  = tail.j;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_elem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    assign head      = fifo_mem[rd_ptr_reg];
    assign c_valid   = (count_reg != '0);
    assign c_data    = c_valid ? head.data : '0;
    assign c_row     = c_valid ? head.row : '0;
    assign c_col     = c_valid ? head.col : '0;

    assign busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);
    assign a_rd_en   = issue;
    assign b_rd_en   = issue;
    assign a_rd_addr = a_addr_reg;
    assign b_rd_addr = b_addr_reg;
endmodule

// File: tb/tb_gemm_mac_sequencer.sv
// Directed bench: models the operand buffers plus MAC, scoreboards every C element
// and checks read/valid/done timing per job.
module tb_gemm_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_m = '0, cfg_p = '0, cfg_kc = '0;
    logic        busy, done, a_rd_en, b_rd_en, c_valid;
    logic        c_ready = 1'b1;
    logic [15:0] a_rd_addr, b_rd_addr;
    logic [31:0] mac_result;
    logic [39:0] c_data;
    logic [7:0]  c_row, c_col;

    gemm_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_p(cfg_p), .cfg_kc(cfg_kc),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .mac_result(mac_result),
        .c_valid(c_valid), .c_ready(c_ready),
        .c_data(c_data), .c_row(c_row), .c_col(c_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    logic signed [15:0] amem [64][8];
    logic signed [15:0] bmem [64][8];
    logic [31:0] mac_s0, mac_s1;
    exp_t exp_q [$];
    int   cyc = 0;
    int   checks = 0, passes = 0;
    int   t0 = 0, reads = 0, first_rd = -1, last_rd = -1, first_cv = -1;
    int   done_cnt = 0, done_rel = -1, busy_seen = 0, en_mismatch = 0, outs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dot32(input int a, input int b);
        longint s = 0;
        for (int l = 0; l < 8; l++) s += longint'(amem[a][l]) * longint'(bmem[b][l]);
        return s[31:0];
    endfunction

    function automatic logic [39:0] exp_elem(input int i, input int j, input int kc);
        longint acc = 0;
        logic [31:0] r;
        for (int k = 0; k < kc; k++) begin
            r = dot32(i*kc + k, j*kc + k);
            acc += longint'(signed'(r));
        end
        return acc[39:0];
    endfunction

    // Buffer read latency 1 plus registered multiply: result two cycles after the read.
    always @(posedge clk) begin
        if (rst) begin
            mac_s0 <= '0;
            mac_s1 <= '0;
        end else begin
            mac_s1 <= mac_s0;
            mac_s0 <= a_rd_en ? dot32(int'(a_rd_addr[5:0]), int'(b_rd_addr[5:0])) : '0;
        end
    end
    assign mac_result = mac_s1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic run_monitor();
        exp_t e;
        int   rel;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (start) begin
                t0 = cyc; reads = 0; first_rd = -1; last_rd = -1; first_cv = -1;
                done_cnt = 0; done_rel = -1; busy_seen = 0; en_mismatch = 0; outs = 0;
            end
            rel = cyc - t0;
            if (a_rd_en) begin
                reads++;
                if (first_rd < 0) first_rd = rel;
                last_rd = rel;
            end
            if (a_rd_en !== b_rd_en) en_mismatch++;
            if (c_valid && first_cv < 0) first_cv = rel;
            if (busy) busy_seen = 1;
            if (done) begin
                if (done_cnt == 0) done_rel = rel;
                done_cnt++;
            end
            if (c_valid && c_ready) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL c_elem: unexpected output row=%0d col=%0d data=%0d", c_row, c_col, $signed(c_data));
                end else begin
                    e = exp_q.pop_front();
                    if (c_data === e.data && c_row === e.row && c_col === e.col) begin
                        passes++;
                        $display("out (%0d,%0d) data=%0d", c_row, c_col, $signed(c_data));
                    end else begin
                        $display("FAIL c_elem: got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                                 c_row, c_col, $signed(c_data), e.row, e.col, $signed(e.data));
                    end
                end
            end
        end
    endtask

    task automatic clear_mem();
        for (int w = 0; w < 64; w++)
            for (int l = 0; l < 8; l++) begin
                amem[w][l] = '0;
                bmem[w][l] = '0;
            end
    endtask

    task automatic push_model(input int m, input int p, input int kc);
        exp_t e;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < p; j++) begin
                e.data = exp_elem(i, j, kc);
                e.row  = 8'(i);
                e.col  = 8'(j);
                exp_q.push_back(e);
            end
    endtask

    task automatic launch(input int m, input int p, input int kc);
        @(posedge clk); #1;
        cfg_m = 8'(m); cfg_p = 8'(p); cfg_kc = 8'(kc); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        #1;
        chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_en_match"}, 64'(en_mismatch), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
        chk({name, "_rd_en"}, 64'({a_rd_en, b_rd_en}), 64'd0);
        chk({name, "_addr"}, 64'({a_rd_addr, b_rd_addr}), 64'd0);
        chk({name, "_c_valid"}, 64'(c_valid), 64'd0);
        chk({name, "_c_out"}, 64'({c_data, c_row, c_col}), 64'd0);
    endtask

    initial begin
        exp_t   e;
        longint big;
        int     n;
        fork
            run_monitor();
        join_none

        clear_mem();
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single element: all-ones A against 1..8 -> 36.
        for (int l = 0; l < 8; l++) begin
            amem[0][l] = 16'sd1;
            bmem[0][l] = 16'(l + 1);
        end
        e.data = 40'd36; e.row = 8'd0; e.col = 8'd0;
        exp_q.push_back(e);
        launch(1, 1, 1);
        wait_done("single", 50);
        chk("single_done_cycle", 64'(done_rel), 64'd6);
        chk("single_reads", 64'(reads), 64'd1);

        // Latency and order.
        clear_mem();
        for (int w = 0; w < 6; w++)
            for (int l = 0; l < 8; l++) begin
                amem[w][l] = 16'(w + 1 - l);
                bmem[w][l] = 16'((w*3 + l) % 7 - 3);
            end
        push_model(2, 3, 2);
        launch(2, 3, 2);
        wait_done("order", 100);
        chk("order_reads", 64'(reads), 64'd12);
        chk("order_first_read", 64'(first_rd), 64'd1);
        chk("order_last_read", 64'(last_rd), 64'd12);
        chk("order_first_valid", 64'(first_cv), 64'd5);
        chk("order_done_cycle", 64'(done_rel), 64'd17);
        chk("order_outs", 64'(outs), 64'd6);

        // Backpressure: credits stop issue after four elements.
        clear_mem();
        for (int w = 0; w < 8; w++)
            for (int l = 0; l < 8; l++) begin
                amem[w][l] = 16'(l - 4);
                bmem[w][l] = 16'(w*l + 1);
            end
        @(posedge clk); #1;
        c_ready = 1'b0;
        push_model(1, 8, 1);
        launch(1, 8, 1);
        repeat (20) @(negedge clk);
        #1;
        chk("bp_reads", 64'(reads), 64'd4);
        chk("bp_rd_en_held", 64'(a_rd_en), 64'd0);
        chk("bp_c_valid_held", 64'(c_valid), 64'd1);
        @(posedge clk); #1;
        c_ready = 1'b1;
        wait_done("bp", 100);
        chk("bp_outs", 64'(outs), 64'd8);
        chk("bp_total_reads", 64'(reads), 64'd8);

        // Signed extreme: one active lane keeps each chunk inside the 32-bit MAC result.
        clear_mem();
        for (int w = 0; w < 32; w++) begin
            amem[w][0] = -16'sd32768;
            bmem[w][0] = 16'sd32767;
        end
        big = -64'sd34358689792;
        e.data = big[39:0]; e.row = 8'd0; e.col = 8'd0;
        exp_q.push_back(e);
        launch(1, 1, 32);
        wait_done("extreme", 200);
        chk("extreme_outs", 64'(outs), 64'd1);

        // Zero config.
        launch(1, 0, 1);
        wait_done("zero", 20);
        chk("zero_reads", 64'(reads), 64'd0);
        chk("zero_busy", 64'(busy_seen), 64'd0);
        chk("zero_done_cycle", 64'(done_rel), 64'd1);

        // Reset mid-RUN, then restart with fresh data.
        clear_mem();
        for (int w = 0; w < 12; w++)
            for (int l = 0; l < 8; l++) begin
                amem[w][l] = 16'(w - l);
                bmem[w][l] = 16'(l - w + 2);
            end
        launch(4, 4, 3);
        n = 0;
        while (reads < 5 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_mid_reads", 64'(reads), 64'd5);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        chk_outputs_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int w = 0; w < 12; w++)
            for (int l = 0; l < 8; l++) begin
                amem[w][l] = 16'(3*w - 2*l - 5);
                bmem[w][l] = 16'(l*w - 7);
            end
        push_model(4, 4, 3);
        launch(4, 4, 3);
        wait_done("restart", 300);
        chk("restart_outs", 64'(outs), 64'd16);
        chk("restart_reads", 64'(reads), 64'd48);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
